// File: rtl/transmision.sv
// UART 8N1 transmitter: start bit, eight data bits LSB first, stop bit on tx.
// Each bit lasts BAUD_DIV clock cycles. All outputs are registered.
module transmision #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       rw,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int              CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            baud_wrap;

    assign baud_wrap = (cnt_q == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the shift register is pure datapath, always loaded before use, so it needs no reset.
    always_ff @(posedge clk_in) begin
        shreg_q <= shreg_d;
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        unique case (state_q)
            IDLE: begin
                if (rw) begin
                    state_d = START;
                    cnt_d   = '0;
                    shreg_d = din;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    cnt_d   = '0;
                    shreg_d = shreg_q >> 1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered value matches the state it enters.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        done_d = 1'b0;
        unique case (state_d)
            IDLE:    busy_d = 1'b0;
            START:   tx_d   = 1'b0;
            DATA:    tx_d   = shreg_d[0];
            STOP:    tx_d   = 1'b1;
            DONE:    done_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_transmision.sv
// Directed bench for transmision: one instance at BAUD_DIV=16 and one at the minimum BAUD_DIV=2.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_transmision;

    logic       clk = 1'b0;
    logic       reset;
    logic       rw;
    logic [7:0] din;
    logic       busy16, done16, tx16;
    logic       busy2, done2, tx2;
    int         sel = 16;
    logic       tx_m, busy_m, done_m;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    assign tx_m   = (sel == 2) ? tx2   : tx16;
    assign busy_m = (sel == 2) ? busy2 : busy16;
    assign done_m = (sel == 2) ? done2 : done16;

    transmision #(.BAUD_DIV(16)) dut16 (
        .clk_in (clk),
        .reset  (reset),
        .rw     (rw),
        .din    (din),
        .busy   (busy16),
        .done   (done16),
        .tx     (tx16)
    );

    transmision #(.BAUD_DIV(2)) dut2 (
        .clk_in (clk),
        .reset  (reset),
        .rw     (rw),
        .din    (din),
        .busy   (busy2),
        .done   (done2),
        .tx     (tx2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic wait_start(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (tx_m === 1'b0) seen = 1'b1;
        end
        check({tag, " start bit seen"}, 32'(seen), 32'd1);
    endtask

    // Entered on the falling edge of the first START cycle; leaves on the DONE cycle.
    task automatic check_frame(input string tag, input int div, input logic [7:0] b, input bit poke);
        logic [9:0] bits;
        int         bad_tx;
        int         bad_st;
        bits   = {1'b1, b, 1'b0};
        bad_st = 0;
        for (int k = 0; k < 10; k++) begin
            bad_tx = 0;
            for (int c = 0; c < div; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                if (tx_m !== bits[k]) bad_tx++;
                if (busy_m !== 1'b1 || done_m !== 1'b0) bad_st++;
                if (poke) begin
                    if (k >= 2 && k <= 5) begin
                        din = 8'hFF;
                        rw  = ~rw;
                    end else if (k == 6) begin
                        rw = 1'b0;
                    end
                end
            end
            check($sformatf("%s bit%0d tx errors", tag, k), 32'(bad_tx), 32'd0);
        end
        check({tag, " busy/done errors in frame"}, 32'(bad_st), 32'd0);
        @(negedge clk);
        check({tag, " done pulse"},   32'(done_m), 32'd1);
        check({tag, " busy on done"}, 32'(busy_m), 32'd1);
        check({tag, " tx on done"},   32'(tx_m),   32'd1);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, " idle tx"},   32'(tx_m),   32'd1);
        check({tag, " idle busy"}, 32'(busy_m), 32'd0);
        check({tag, " idle done"}, 32'(done_m), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        rw = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int bad;

        // Reset held with a pending request: nothing may start.
        reset = 1'b0;
        rw    = 1'b1;
        din   = 8'h33;
        bad   = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx16 !== 1'b1 || busy16 !== 1'b0 || done16 !== 1'b0) bad++;
            if (tx2  !== 1'b1 || busy2  !== 1'b0 || done2  !== 1'b0) bad++;
        end
        check("reset outputs errors", 32'(bad), 32'd0);

        // Release with rw still high: the frame begins only now.
        reset = 1'b1;
        sel   = 16;
        wait_start("post-reset", 1);
        rw = 1'b0;
        check_frame("post-reset", 16, 8'h33, 1'b0);
        check_idle("post-reset");
        idle_cycles(40);

        // Single frame, one-cycle request pulse.
        din = 8'b0011_0011;
        rw  = 1'b1;
        wait_start("single", 4);
        rw = 1'b0;
        check_frame("single", 16, 8'h33, 1'b0);
        check_idle("single");
        idle_cycles(40);

        // Mid-frame din and rw changes must not disturb the frame.
        din = 8'h33;
        rw  = 1'b1;
        wait_start("midchg", 4);
        rw = 1'b0;
        check_frame("midchg", 16, 8'h33, 1'b1);
        check_idle("midchg");
        check_idle("midchg late");
        idle_cycles(200);

        // Held request: back-to-back frames with a two-cycle idle gap.
        din = 8'h33;
        rw  = 1'b1;
        wait_start("held", 4);
        for (int f = 0; f < 12; f++) begin
            check_frame($sformatf("held f%0d", f), 16, 8'h33, 1'b0);
            if (f == 11) rw = 1'b0;
            check_idle($sformatf("held gap f%0d", f));
            if (f < 11) begin
                @(negedge clk);
                check($sformatf("held restart f%0d", f), 32'(tx_m), 32'd0);
            end
        end
        idle_cycles(200);

        // Reset during data bit 3 aborts the frame at once.
        din = 8'h96;
        rw  = 1'b1;
        wait_start("abort", 4);
        rw = 1'b0;
        for (int i = 0; i < 68; i++) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort tx",   32'(tx16),   32'd1);
        check("abort busy", 32'(busy16), 32'd0);
        check("abort done", 32'(done16), 32'd0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        reset = 1'b1;
        bad   = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done16 !== 1'b0 || busy16 !== 1'b0 || tx16 !== 1'b1) bad++;
        end
        check("abort quiet after release", 32'(bad), 32'd0);
        din = 8'h5C;
        rw  = 1'b1;
        wait_start("after-abort", 4);
        rw = 1'b0;
        check_frame("after-abort", 16, 8'h5C, 1'b0);
        check_idle("after-abort");
        idle_cycles(200);

        // Minimum divisor.
        sel = 2;
        din = 8'hA5;
        rw  = 1'b1;
        wait_start("div2", 4);
        rw = 1'b0;
        check_frame("div2", 2, 8'hA5, 1'b0);
        check_idle("div2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
